// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte over open-drain CLK/DAT.
// Ports:
//   clk, reset (async, active-low)  system clock and reset
//   send, cmd[7:0]                  start request (IDLE only) and command byte
//   ps2_clk_in, ps2_dat_in          raw pin levels
//   ps2_clk_oe, ps2_dat_oe          1 = pull the pin low, 0 = release
//   busy, done                      transaction in flight / one-cycle end pulse
//   ack_err, timeout_err            device NAK / no completion within the timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;
  localparam logic [12:0] INH_LAST = 13'(INHIBIT_CYCLES - 1);
  localparam logic [12:0] RTS_LAST = 13'(RTS_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [19:0] to_q, to_d;
  logic [3:0]  n_q, n_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d, dat_q, dat_d, ack_q, ack_d, tmo_q, tmo_d, done_q, done_d;
  // csync_q[1] is the synced clock, csync_q[2] its previous value
  logic [2:0]  csync_q;
  logic [1:0]  dsync_q;
  logic        fall_q, active, tmo_hit;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csync_q <= '1;
      dsync_q <= '1;
      fall_q  <= 1'b0;
    end else begin
      csync_q <= {csync_q[1:0], ps2_clk_in};
      dsync_q <= {dsync_q[0], ps2_dat_in};
      fall_q  <= csync_q[2] & ~csync_q[1];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      dat_q   <= 1'b0;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end
  assign active  = state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE;
  assign tmo_hit = active && to_q == TO_LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = (active && to_q != '1) ? to_q + 20'd1 : to_q;
    n_d     = n_q;
    sh_d    = sh_q;
    par_d   = par_q;
    dat_d   = dat_q;
    ack_d   = ack_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (send) begin
        state_d = INHIBIT;
        sh_d    = cmd;
        par_d   = ~^cmd;
        ack_d   = 1'b0;
        tmo_d   = 1'b0;
        cnt_d   = '0;
      end
      INHIBIT: begin
        state_d = cnt_q == INH_LAST ? RTS : INHIBIT;
        dat_d   = cnt_q == INH_LAST;
        cnt_d   = cnt_q == INH_LAST ? '0 : cnt_q + 13'd1;
      end
      RTS: if (cnt_q == RTS_LAST) begin
        state_d = SHIFT;
        cnt_d   = '0;
        to_d    = '0;
        n_d     = '0;
      end else cnt_d = cnt_q + 13'd1;
      // each fall advances n; n_q is the count before this fall (0..9)
      SHIFT: if (fall_q) begin
        n_d     = n_q + 4'd1;
        dat_d   = n_q < 4'd8 ? ~sh_q[0] : n_q == 4'd8 ? ~par_q : 1'b0;
        sh_d    = sh_q >> 1;
        state_d = n_q == 4'd9 ? ACK : SHIFT;
      end
      ACK: if (fall_q) begin
        n_d     = 4'd11;
        ack_d   = dsync_q[1];
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: if (csync_q[1] & dsync_q[1]) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // timeout wins over any fall in the same cycle and is the sole error reported
    if (tmo_hit) begin
      state_d = IDLE;
      dat_d   = 1'b0;
      tmo_d   = 1'b1;
      ack_d   = 1'b0;
      done_d  = 1'b1;
    end
  end
  assign ps2_clk_oe  = state_q == INHIBIT || state_q == RTS;
  assign ps2_dat_oe  = dat_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign ack_err     = ack_q;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven and scoreboard checks of ps2_host_tx against a PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int RTSC = 20;
  localparam int TMO = 2000;
  localparam int HP = 20;
  logic clk, reset, send, ps2_clk_in, ps2_dat_in;
  logic ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err;
  logic [7:0] cmd;
  logic dev_clk, dev_dat;
  logic [10:0] got_frame;
  int total, bad, done_cnt;
  typedef struct {
    logic        chk_frame;
    logic [10:0] frame;
    logic        ack;
    logic        tmo;
  } exp_t;
  typedef struct {
    logic [7:0]  cmd;
    logic        dev_ack;
    logic [10:0] frame;
    logic        ack_err;
  } vec_t;
  exp_t sbq[$];
  vec_t vt[6];
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTSC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .send(send), .cmd(cmd),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction
  always @(negedge clk) if (reset && done) begin
    exp_t e;
    done_cnt++;
    if (sbq.size() == 0) check("unexpected_done", 1, 0);
    else begin
      e = sbq.pop_front();
      if (e.chk_frame) check("frame", {21'd0, got_frame}, {21'd0, e.frame});
      check("ack_err_at_done", {31'd0, ack_err}, {31'd0, e.ack});
      check("timeout_err_at_done", {31'd0, timeout_err}, {31'd0, e.tmo});
      check("busy_at_done", {31'd0, busy}, 0);
      check("oe_at_done", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    end
  end
  task automatic push_exp(input logic cf, input logic [10:0] fr, input logic a, input logic t);
    exp_t e;
    e.chk_frame = cf;
    e.frame = fr;
    e.ack = a;
    e.tmo = t;
    sbq.push_back(e);
  endtask
  task automatic start_tx(input logic [7:0] c);
    int k;
    @(negedge clk);
    cmd = c;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("accept_state", {29'd0, ack_err, timeout_err, busy}, 3'b001);
    k = 0;
    while (ps2_clk_oe && !ps2_dat_oe && k < 10000) begin k++; @(negedge clk); end
    check("inhibit_len", k, INH);
    k = 0;
    while (ps2_clk_oe && ps2_dat_oe && k < 10000) begin k++; @(negedge clk); end
    check("rts_len", k, RTSC);
    check("released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask
  task automatic dev_frame(input logic ack, input int nf);
    got_frame = '0;
    for (int i = 0; i < nf; i++) begin
      repeat (HP) @(negedge clk);
      got_frame[i] = ps2_dat_in;
      if (i == 10) dev_dat = ack;
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
    end
    if (nf == 11) begin
      repeat (HP) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask
  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 5000) begin @(negedge clk); k++; end
    check("done_seen", {31'd0, done_cnt > prev}, 1);
  endtask
  initial begin
    int prev, k;
    total = 0; bad = 0; done_cnt = 0;
    vt[0] = '{8'hED, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0};
    vt[1] = '{8'hF4, 1'b0, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0};
    vt[2] = '{8'h01, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b0};
    vt[3] = '{8'hFF, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0};
    vt[4] = '{8'hA5, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0}, 1'b1};
    vt[5] = '{8'h55, 1'b0, {1'b1, 1'b1, 8'h55, 1'b0}, 1'b0};
    reset = 1'b0; send = 1'b0; cmd = '0; dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      prev = done_cnt;
      push_exp(1'b1, vt[v].frame, vt[v].ack_err, 1'b0);
      start_tx(vt[v].cmd);
      dev_frame(vt[v].dev_ack, 11);
      wait_done(prev);
    end
    // device silent after release: timeout exactly TMO cycles after release
    push_exp(1'b0, '0, 1'b0, 1'b1);
    start_tx(8'h12);
    k = 0;
    while (!done && k < 10000) begin @(negedge clk); k++; end
    check("timeout_len", k, TMO);
    repeat (2) @(negedge clk);
    // reset mid-frame after 4 data bits
    start_tx(8'h5A);
    dev_frame(1'b0, 5);
    #2 reset = 1'b0;
    #1 check("async_reset", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 0);
    dev_clk = 1'b1; dev_dat = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    prev = done_cnt;
    push_exp(1'b1, {1'b1, 1'b1, 8'h5A, 1'b0}, 1'b0, 1'b0);
    start_tx(8'h5A);
    dev_frame(1'b0, 11);
    wait_done(prev);
    // send mid-frame with a different byte must be ignored
    prev = done_cnt;
    push_exp(1'b1, {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b0, 1'b0);
    start_tx(8'h3C);
    fork
      dev_frame(1'b0, 11);
      begin
        repeat (150) @(negedge clk);
        cmd = 8'hC3;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
    join
    wait_done(prev);
    repeat (300) @(negedge clk);
    check("single_done", done_cnt, prev + 1);
    check("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
